// File: rtl/seg_scan_decoder.sv
// Loop-back reader for a 4-digit multiplexed, active-low seven-segment display.
// Waits for each {an,seg} pair to hold steady, then decodes it into a per-digit register file.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,  // 1..255
  parameter int CNT_W         = 8   // 2**CNT_W > STABLE_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err,
  output logic [3:0]  err_digit,
  output logic        conflict
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Sample stage: last seen pair, how long it has held, and whether this window has captured yet.
  logic [3:0]       s_an;
  logic [7:0]       s_seg;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  logic             same;
  logic             capture;
  logic [3:0]       sel;
  logic             sel_none;
  logic             sel_multi;
  logic [1:0]       idx;
  logic [3:0]       dec_val;
  logic             dec_legal;
  logic             dec_blank;

  assign same      = (an == s_an) && (seg == s_seg);
  assign capture   = same && armed && (cnt == CNT_LAST);
  assign sel       = ~s_an;
  assign sel_none  = (sel == 4'd0);
  assign sel_multi = ((sel & (sel - 4'd1)) != 4'd0);

  always_comb begin
    idx = 2'd0;
    case (sel)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Inverse of the standard hex font; DP (seg[7]) is handled separately.
  always_comb begin
    dec_val   = 4'd0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (s_seg[6:0])
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // upd and err are single-cycle pulses, high in the cycle after the capturing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_an      <= 4'hF;
      s_seg     <= 8'hFF;
      cnt       <= '0;
      armed     <= 1'b1;
      digits    <= 16'd0;
      dp        <= 4'd0;
      valid     <= 4'd0;
      upd       <= 1'b0;
      upd_idx   <= 2'd0;
      err       <= 1'b0;
      err_digit <= 4'd0;
      conflict  <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;

      if (!same) begin
        s_an  <= an;
        s_seg <= seg;
        cnt   <= '0;
        armed <= 1'b1;
      end else if (cnt < CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (capture) begin
        armed <= 1'b0;
        if (sel_multi) begin
          err      <= 1'b1;
          conflict <= 1'b1;
        end else if (!sel_none) begin
          if (dec_legal) begin
            digits[{idx, 2'b00} +: 4] <= dec_val;
            dp[idx]                   <= ~s_seg[7];
            valid[idx]                <= 1'b1;
            upd                       <= 1'b1;
            upd_idx                   <= idx;
          end else if (dec_blank) begin
            dp[idx]    <= ~s_seg[7];
            valid[idx] <= 1'b0;
            upd        <= 1'b1;
            upd_idx    <= idx;
          end else begin
            err            <= 1'b1;
            err_digit[idx] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
